spi_ram_ctrl: RTL and testbench

- Command controller between the SPI slave (rx_data/rx_valid, tx_data/tx_valid) and the single-port byte RAM of the SPI wrapper.
- Decodes the 2-bit opcode carried in rx_data[9:8] and holds the write and read address registers.
- Sequences RAM write and read accesses, absorbing a parameterised RAM read latency.
- Returns read bytes to the SPI slave and flags protocol-order errors and dropped commands.

---
 rtl/spi_ram_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: SPI command decoder and byte-RAM sequencer with registered outputs.
// Optional address auto-increment: define SPI_RAM_CTRL_ADDR_AUTOINC_EN.
module spi_ram_ctrl #(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [9:0]           rx_data,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 err_seq,
    input  logic                 err_clr,
    output logic                 cmd_drop
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } state_e;

    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    state_e state_q, state_d;

    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [1:0]           cnt_q, cnt_d;

    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 err_q, err_d;
    logic                 drop_q, drop_d;

    logic       accept;
    logic       rd_done;
    logic       err_set;
    logic [1:0] op;

    assign op      = rx_data[9:8];
    assign accept  = rx_valid && (state_q == IDLE);
    assign rd_done = (state_q == RD_WAIT) && (cnt_q == 2'd0);
    assign err_set = accept && (op == 2'b11) && !rd_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    unique case (op)
                        2'b01:   state_d = WRITE;
                        2'b11:   state_d = rd_vld_q ? RD_ISSUE : RESP;
                        default: state_d = IDLE;
                    endcase
                end
            end
            WRITE:    state_d = IDLE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = (cnt_q == 2'd0) ? RESP : RD_WAIT;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en_d    = (state_d == WRITE) || (state_d == RD_ISSUE);
        mem_we_d    = (state_d == WRITE);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_valid_d  = (state_d == RESP);
        tx_data_d   = tx_data_q;
        drop_d      = rx_valid && (state_q != IDLE);
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        rd_vld_d    = rd_vld_q;
        cnt_d       = cnt_q;

        if (state_d == WRITE) begin
            mem_addr_d  = wr_addr_q;
            mem_wdata_d = rx_data[7:0];
        end
        if (state_d == RD_ISSUE) begin
            mem_addr_d = rd_addr_q;
        end

        if (accept && (op == 2'b00)) begin
            wr_addr_d = rx_data[ADDR_SIZE-1:0];
        end
        if (accept && (op == 2'b10)) begin
            rd_addr_d = rx_data[ADDR_SIZE-1:0];
            rd_vld_d  = 1'b1;
        end

        if (state_q == RD_ISSUE) begin
            cnt_d = CNT_INIT;
        end else if ((state_q == RD_WAIT) && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end

        // Orphan read-data still answers with a zero byte to keep the slave moving
        if (err_set) begin
            tx_data_d = 8'h00;
        end else if (rd_done) begin
            tx_data_d = mem_rdata;
        end

`ifdef SPI_RAM_CTRL_ADDR_AUTOINC_EN
        if (state_q == WRITE) begin
            wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
        end
        if (rd_done) begin
            rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
        end
`else
        if (rd_done) begin
            rd_vld_d = 1'b0;
        end
`endif

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            rd_vld_q    <= 1'b0;
            cnt_q       <= 2'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            rd_vld_q    <= rd_vld_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != IDLE);
    assign err_seq   = err_q;
    assign cmd_drop  = drop_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: random command stream against a transaction-level model
// of the controller plus a behavioural RAM with RD_LATENCY-stage read pipe.
module tb_spi_ram_ctrl;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [9:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       err_seq;
    logic       err_clr;
    logic       cmd_drop;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] ram     [256];
    logic [7:0] pipe    [LAT];
    logic [7:0] m_wr;
    logic [7:0] m_rd;
    bit         m_vld;
    bit         m_err;

    always #5 clk = ~clk;

    spi_ram_ctrl #(
        .ADDR_SIZE (8),
        .RD_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .err_seq  (err_seq),
        .err_clr  (err_clr),
        .cmd_drop (cmd_drop)
    );

    // RAM: read data appears LAT cycles after the mem_en cycle, garbage otherwise
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 8'($urandom);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d,
                          input bit drop, input bit clr);
        logic [7:0] exp;
        int         k;
        bit         got;
        rx_valid = 1'b1;
        rx_data  = {op, d};
        err_clr  = clr;
        @(negedge clk);
        rx_valid = 1'b0;
        err_clr  = 1'b0;
        if (op == 2'b11 && !m_vld) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        chk("err_seq", 32'(err_seq), 32'(m_err));
        chk("drop_idle", 32'(cmd_drop), 0);
        case (op)
            2'b00: begin
                m_wr = d;
                chk("wa_busy", 32'(busy), 0);
                chk("wa_men", 32'(mem_en), 0);
            end
            2'b10: begin
                m_rd  = d;
                m_vld = 1'b1;
                chk("ra_busy", 32'(busy), 0);
                chk("ra_men", 32'(mem_en), 0);
            end
            2'b01: begin
                chk("wr_en", 32'(mem_en), 1);
                chk("wr_we", 32'(mem_we), 1);
                chk("wr_addr", 32'(mem_addr), 32'(m_wr));
                chk("wr_data", 32'(mem_wdata), 32'(d));
                chk("wr_busy", 32'(busy), 1);
                ref_mem[m_wr] = d;
                @(negedge clk);
                chk("wr_busy_end", 32'(busy), 0);
                chk("wr_en_end", 32'(mem_en), 0);
`ifdef SPI_RAM_CTRL_ADDR_AUTOINC_EN
                m_wr = m_wr + 8'd1;
`endif
            end
            default: begin
                if (!m_vld) begin
                    chk("orph_txv", 32'(tx_valid), 1);
                    chk("orph_txd", 32'(tx_data), 0);
                    chk("orph_men", 32'(mem_en), 0);
                    @(negedge clk);
                    chk("orph_busy", 32'(busy), 0);
                    chk("orph_txv_end", 32'(tx_valid), 0);
                end else begin
                    chk("rd_en", 32'(mem_en), 1);
                    chk("rd_we", 32'(mem_we), 0);
                    chk("rd_addr", 32'(mem_addr), 32'(m_rd));
                    exp = ref_mem[m_rd];
                    got = 1'b0;
                    k   = 1;
                    while (!got && k <= LAT + 4) begin
                        @(negedge clk);
                        k++;
                        if (drop && k == 2) begin
                            rx_valid = 1'b1;
                            rx_data  = 10'($urandom);
                        end
                        if (drop && k == 3) begin
                            rx_valid = 1'b0;
                            chk("cmd_drop", 32'(cmd_drop), 1);
                        end
                        if (drop && k == 4) chk("drop_once", 32'(cmd_drop), 0);
                        if (k > 1 && !tx_valid) chk("rd_no_men", 32'(mem_en), 0);
                        if (tx_valid) got = 1'b1;
                    end
                    chk("rd_tx_seen", 32'(got), 1);
                    if (got) begin
                        chk("rd_lat", 32'(k), 32'(LAT + 2));
                        chk("rd_data", 32'(tx_data), 32'(exp));
                        chk("rd_err", 32'(err_seq), 32'(m_err));
                        @(negedge clk);
                        chk("rd_txv_end", 32'(tx_valid), 0);
                        chk("rd_busy_end", 32'(busy), 0);
                        chk("rd_hold", 32'(tx_data), 32'(exp));
                    end
`ifdef SPI_RAM_CTRL_ADDR_AUTOINC_EN
                    m_rd = m_rd + 8'd1;
`else
                    m_vld = 1'b0;
`endif
                end
            end
        endcase
    endtask

    task automatic clr_only();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 1'b0;
        chk("err_clr", 32'(err_seq), 0);
    endtask

    task automatic reset_mid_read();
        do_cmd(2'b10, 8'h40, 1'b0, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 10'h300;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_men", 32'(mem_en), 0);
        chk("rst_txv", 32'(tx_valid), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        m_wr = 8'h00;
        m_rd = 8'h00;
        m_vld = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            chk("rst_no_txv", 32'(tx_valid), 0);
        end
        do_cmd(2'b11, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] op;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 10'h000;
        err_clr  = 1'b0;
        m_wr     = 8'h00;
        m_rd     = 8'h00;
        m_vld    = 1'b0;
        m_err    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_seq), 0);
        chk("rst_drop", 32'(cmd_drop), 0);

        do_cmd(2'b11, 8'h00, 1'b0, 1'b0);
        clr_only();
        do_cmd(2'b00, 8'h12, 1'b0, 1'b0);
        do_cmd(2'b01, 8'hA5, 1'b0, 1'b0);
        do_cmd(2'b10, 8'h12, 1'b0, 1'b0);
        do_cmd(2'b11, 8'h00, 1'b0, 1'b0);
        do_cmd(2'b11, 8'h00, 1'b0, 1'b0);
        do_cmd(2'b11, 8'h00, 1'b0, 1'b1);
        clr_only();
        do_cmd(2'b10, 8'h12, 1'b0, 1'b0);
        do_cmd(2'b11, 8'h00, 1'b1, 1'b0);
        do_cmd(2'b00, 8'hFF, 1'b0, 1'b0);
        do_cmd(2'b01, 8'h11, 1'b0, 1'b0);
        do_cmd(2'b01, 8'h22, 1'b0, 1'b0);
        do_cmd(2'b10, 8'hFF, 1'b0, 1'b0);
        do_cmd(2'b11, 8'h00, 1'b0, 1'b0);
        do_cmd(2'b11, 8'h00, 1'b0, 1'b0);
        reset_mid_read();

        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            do_cmd(op, 8'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) == 0) clr_only();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
